pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer that replaces the free-running PC with a fetch-handshaked, redirectable one. It generates the fetch address for the instruction memory, advances only when the fetch stage accepts the current address, and supports branch/jump redirect, trap entry, halt/resume and misaligned-target detection. It sits at the front of the fetch stage and feeds instruction memory and the IF/ID pipeline register.

Parameters:
XLEN, 32, width of the PC and target buses.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or misaligned redirect.
INSTR_BYTES, 4, increment step; legal values 2 or 4; also the alignment granule.
CNT_WIDTH, 32, width of the accepted-fetch counter.

Ports:
i_clock  input  1  system clock, all state updates on its rising edge.
i_resetn  input  1  synchronous, active-low reset.
i_ready  input  1  fetch stage accepts o_PC this cycle.
i_redirect  input  1  branch/jump taken; load i_target.
i_target  input  XLEN  redirect target address.
i_trap  input  1  exception/interrupt; load TRAP_VECTOR.
i_halt  input  1  request to stop fetching.
i_resume  input  1  leave HALT at the held PC.
o_PC  output  XLEN  current fetch address.
o_valid  output  1  o_PC is a valid fetch request.
o_PC_next_seq  output  XLEN  combinational o_PC + INSTR_BYTES (link value).
o_misaligned  output  1  one-cycle pulse: rejected misaligned redirect.
o_fetch_count  output  CNT_WIDTH  number of accepted fetches, saturating.

Behaviour:
- Reset is synchronous and active-low: i_resetn=0 sampled at a rising i_clock edge has top priority, including mid-operation. o_PC=RESET_VECTOR, state=BOOT, o_valid=0, o_misaligned=0, o_fetch_count=0.
- FSM states are BOOT, RUN and HALT.
- BOOT: o_valid=0 and PC is held. Moves to RUN unconditionally on the next edge, so the first valid fetch of RESET_VECTOR appears one cycle after reset release.
- RUN: o_valid=1. A fetch fires when o_valid and i_ready are both 1. Per-edge priority:
  1. i_trap: o_PC<=TRAP_VECTOR; stay in RUN.
  2. i_redirect with i_target aligned (low log2(INSTR_BYTES) bits zero): o_PC<=i_target.
  3. i_redirect with i_target misaligned: o_PC<=TRAP_VECTOR; o_misaligned=1 for exactly the following cycle.
  4. i_halt: state<=HALT; o_PC held.
  5. fire: o_PC<=o_PC+INSTR_BYTES.
  6. Otherwise o_PC is held and o_valid stays 1, with no change until accepted.
- Trap and redirect take effect regardless of i_ready; the pending fetch is squashed.
- A fire is still counted if it coincides with trap or redirect.
- Arithmetic: the increment wraps modulo 2^XLEN. An o_PC of all-ones minus (INSTR_BYTES-1) advances to 0, with no flag.
- o_fetch_count increments by 1 on each fire and saturates at 2^CNT_WIDTH-1.
- HALT: o_valid=0 and o_PC is held.
  - i_trap: o_PC<=TRAP_VECTOR, state<=RUN.
  - else i_resume: state<=RUN at the same o_PC.
  - i_redirect is ignored; i_halt together with i_resume resolves to resume.
- o_misaligned is 0 in every cycle other than the pulse cycle.
- o_PC_next_seq is purely combinational from o_PC.
- Illegal INSTR_BYTES (not 2 or 4) is an elaboration error.

Test Plan:
- Reset and boot: hold i_resetn=0 for 2 cycles, then release with i_ready=1. Cycle 1: o_valid=0, o_PC=0. Then 0x0, 0x4, 0x8 on successive cycles, and o_fetch_count=3 after three fires.
- Backpressure: in RUN at o_PC=0x10, i_ready=0 for 3 cycles. o_PC stays 0x10 with o_valid=1. i_ready=1 then gives o_PC=0x14 and the count increments once.
- Redirect priority: i_redirect=1, i_target=0x200 and i_ready=0 at o_PC=0x20 gives o_PC=0x200 next. i_trap and i_redirect together give o_PC=0x100.
- Misaligned: i_redirect with i_target=0x202 gives o_PC=0x100, o_misaligned=1 for one cycle then 0. With INSTR_BYTES=2 the same target is accepted and o_PC=0x202.
- Halt and resume: i_halt at o_PC=0x40 gives o_valid=0 and o_PC=0x40 held. i_redirect during HALT is ignored. i_resume gives o_valid=1 and o_PC=0x40.
- Wrap, saturation and mid-op reset:
  - o_PC=0xFFFF_FFFC with a fire gives 0x0000_0000.
  - CNT_WIDTH=2 saturates at 3.
  - i_resetn=0 while in HALT gives o_PC=RESET_VECTOR, BOOT and count 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-handshaked, redirectable program-counter sequencer.
// Supports trap entry, halt/resume and rejection of misaligned redirect targets.
module pc_sequencer #(
   parameter int unsigned         XLEN         = 32,
   parameter logic [XLEN-1:0]     RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0]     TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned         INSTR_BYTES  = 4,
   parameter int unsigned         CNT_WIDTH    = 32
) (
   input  logic                 i_clock,
   input  logic                 i_resetn,
   input  logic                 i_ready,
   input  logic                 i_redirect,
   input  logic [XLEN-1:0]      i_target,
   input  logic                 i_trap,
   input  logic                 i_halt,
   input  logic                 i_resume,
   output logic [XLEN-1:0]      o_PC,
   output logic                 o_valid,
   output logic [XLEN-1:0]      o_PC_next_seq,
   output logic                 o_misaligned,
   output logic [CNT_WIDTH-1:0] o_fetch_count
);

   generate
      if (INSTR_BYTES != 2 && INSTR_BYTES != 4) begin : g_bad_instr_bytes
         $error("pc_sequencer: INSTR_BYTES must be 2 or 4");
      end
   endgenerate

   localparam int unsigned ALIGN_BITS = (INSTR_BYTES == 2) ? 1 : 2;
   localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [XLEN-1:0]       pc_q, pc_d;
   logic                  mis_q, mis_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  fire;
   logic                  target_aligned;

   assign o_PC          = pc_q;
   assign o_valid       = (state_q == RUN);
   assign o_PC_next_seq = pc_q + STEP;
   assign o_misaligned  = mis_q;
   assign o_fetch_count = cnt_q;

   assign fire           = o_valid && i_ready;
   assign target_aligned = (i_target[ALIGN_BITS-1:0] == '0);

   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      mis_d   = 1'b0;
      cnt_d   = cnt_q;

      // A fire is counted even when a trap or redirect squashes the advance.
      if (fire && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end

      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (i_trap) begin
               pc_d = TRAP_VECTOR;
            end else if (i_redirect && target_aligned) begin
               pc_d = i_target;
            end else if (i_redirect) begin
               pc_d  = TRAP_VECTOR;
               mis_d = 1'b1;
            end else if (i_halt) begin
               state_d = HALT;
            end else if (fire) begin
               pc_d = pc_q + STEP;
            end
         end
         HALT: begin
            if (i_trap) begin
               pc_d    = TRAP_VECTOR;
               state_d = RUN;
            end else if (i_resume) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

endmodule
